// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS: latches a sweep descriptor on start and walks
// f_word from f_start towards f_stop, holding each value for a programmed dwell.
module dds_sweep_ctrl #(
  parameter int unsigned FW_W    = 32,
  parameter int unsigned PW_W    = 12,
  parameter int unsigned DWELL_W = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               axi_clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               mode_i,
  input  logic [FW_W-1:0]    f_start_i,
  input  logic [FW_W-1:0]    f_stop_i,
  input  logic [FW_W-1:0]    f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [PW_W-1:0]    p_word_in_i,
  input  logic [1:0]         wave_type_in_i,
  output logic               dds_en_o,
  output logic [FW_W-1:0]    f_word_o,
  output logic [PW_W-1:0]    p_word_o,
  output logic [1:0]         wave_type_o,
  output logic               upd_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   step_cnt_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep, StHold} state_e;

  state_e state_q, state_d;

  logic [FW_W-1:0]    fstart_q, fstart_d, fstop_q, fstop_d, fstep_q, fstep_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [1:0]         wave_q, wave_d;
  logic               mode_q, mode_d, up_q, up_d;

  logic               dds_en_q, dds_en_d, upd_q, upd_d, busy_q, busy_d, done_q, done_d;
  logic [FW_W-1:0]    f_word_q, f_word_d;
  logic [PW_W-1:0]    p_word_q, p_word_d;
  logic [1:0]         wave_type_q, wave_type_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d, step_cnt_inc;

  // Extra MSB captures carry (up) or borrow (down) so the clamp never wraps.
  logic [FW_W:0]      sum_w, dif_w;
  logic [FW_W-1:0]    nxt_w;
  logic               last_w;

  always_comb begin
    sum_w  = {1'b0, f_word_q} + {1'b0, fstep_q};
    dif_w  = {1'b0, f_word_q} - {1'b0, fstep_q};
    nxt_w  = up_q ? sum_w[FW_W-1:0] : dif_w[FW_W-1:0];
    last_w = (fstep_q == '0) || (f_word_q == fstop_q) ||
             (up_q ? (sum_w[FW_W] || (sum_w[FW_W-1:0] >= fstop_q))
                   : (dif_w[FW_W] || (dif_w[FW_W-1:0] <= fstop_q)));
    step_cnt_inc = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    fstart_d    = fstart_q;
    fstop_d     = fstop_q;
    fstep_d     = fstep_q;
    dwell_d     = dwell_q;
    pw_d        = pw_q;
    wave_d      = wave_q;
    mode_d      = mode_q;
    up_d        = up_q;
    cnt_d       = cnt_q;
    dds_en_d    = dds_en_q;
    f_word_d    = f_word_q;
    p_word_d    = p_word_q;
    wave_type_d = wave_type_q;
    step_cnt_d  = step_cnt_q;
    upd_d       = 1'b0;
    done_d      = 1'b0;

    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      dds_en_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            fstart_d = f_start_i;
            fstop_d  = f_stop_i;
            fstep_d  = f_step_i;
            dwell_d  = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
            pw_d     = p_word_in_i;
            wave_d   = wave_type_in_i;
            mode_d   = mode_i;
            up_d     = (f_start_i <= f_stop_i);
            state_d  = StLoad;
          end
        end
        StLoad: begin
          f_word_d    = fstart_q;
          p_word_d    = pw_q;
          wave_type_d = wave_q;
          dds_en_d    = 1'b1;
          upd_d       = 1'b1;
          step_cnt_d  = CNT_W'(1);
          cnt_d       = dwell_q - DWELL_W'(1);
          state_d     = StDwell;
        end
        StDwell: begin
          if (cnt_q == '0) state_d = StStep;
          else             cnt_d   = cnt_q - DWELL_W'(1);
        end
        StStep: begin
          if (!last_w) begin
            f_word_d   = nxt_w;
            upd_d      = 1'b1;
            step_cnt_d = step_cnt_inc;
            cnt_d      = dwell_q - DWELL_W'(1);
            state_d    = StDwell;
          end else begin
            f_word_d = fstop_q;
            if (f_word_q != fstop_q) begin
              upd_d      = 1'b1;
              step_cnt_d = step_cnt_inc;
            end
            if (mode_q) begin
              state_d = StLoad;
            end else begin
              state_d = StHold;
              done_d  = 1'b1;
            end
          end
        end
        StHold: begin
          if (start_i) state_d = StLoad;
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StLoad) || (state_d == StDwell) || (state_d == StStep);
  end

  always_ff @(posedge axi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      fstart_q    <= '0;
      fstop_q     <= '0;
      fstep_q     <= '0;
      dwell_q     <= '0;
      pw_q        <= '0;
      wave_q      <= '0;
      mode_q      <= 1'b0;
      up_q        <= 1'b0;
      cnt_q       <= '0;
      dds_en_q    <= 1'b0;
      f_word_q    <= '0;
      p_word_q    <= '0;
      wave_type_q <= '0;
      step_cnt_q  <= '0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fstart_q    <= fstart_d;
      fstop_q     <= fstop_d;
      fstep_q     <= fstep_d;
      dwell_q     <= dwell_d;
      pw_q        <= pw_d;
      wave_q      <= wave_d;
      mode_q      <= mode_d;
      up_q        <= up_d;
      cnt_q       <= cnt_d;
      dds_en_q    <= dds_en_d;
      f_word_q    <= f_word_d;
      p_word_q    <= p_word_d;
      wave_type_q <= wave_type_d;
      step_cnt_q  <= step_cnt_d;
      upd_q       <= upd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dds_en_o    = dds_en_q;
  assign f_word_o    = f_word_q;
  assign p_word_o    = p_word_q;
  assign wave_type_o = wave_type_q;
  assign upd_o       = upd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign step_cnt_o  = step_cnt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected updates are queued by the stimulus and
// checked by a monitor on every upd strobe.
module tb_dds_sweep_ctrl;

  localparam int unsigned FW_W    = 32;
  localparam int unsigned PW_W    = 12;
  localparam int unsigned DWELL_W = 24;
  localparam int unsigned CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst, start, abort, mode;
  logic [FW_W-1:0]    f_start, f_stop, f_step;
  logic [DWELL_W-1:0] dwell;
  logic [PW_W-1:0]    p_word_in;
  logic [1:0]         wave_type_in;
  logic               dds_en, upd, busy, done;
  logic [FW_W-1:0]    f_word;
  logic [PW_W-1:0]    p_word;
  logic [1:0]         wave_type;
  logic [CNT_W-1:0]   step_cnt;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .FW_W   (FW_W),
    .PW_W   (PW_W),
    .DWELL_W(DWELL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .axi_clk_i     (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .mode_i        (mode),
    .f_start_i     (f_start),
    .f_stop_i      (f_stop),
    .f_step_i      (f_step),
    .dwell_i       (dwell),
    .p_word_in_i   (p_word_in),
    .wave_type_in_i(wave_type_in),
    .dds_en_o      (dds_en),
    .f_word_o      (f_word),
    .p_word_o      (p_word),
    .wave_type_o   (wave_type),
    .upd_o         (upd),
    .busy_o        (busy),
    .done_o        (done),
    .step_cnt_o    (step_cnt)
  );

  typedef struct packed {
    logic [31:0] f;
    logic [15:0] cnt;
    logic        dn;
    logic [11:0] pw;
    logic [1:0]  wv;
    logic [7:0]  gap;  // expected cycles since previous upd; 0 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_upd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] f, input logic [15:0] c, input logic dn,
                      input logic [11:0] pw, input logic [1:0] wv, input logic [7:0] gap);
    exp_t e;
    e.f = f; e.cnt = c; e.dn = dn; e.pw = pw; e.wv = wv; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: every upd strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_upd = cyc;
    end else if (upd) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_upd: got f_word 0x%0h, expected no update (t=%0t)",
                 f_word, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("f_word", f_word, mon_e.f);
        chk("step_cnt", step_cnt, mon_e.cnt);
        chk("done_with_upd", done, mon_e.dn);
        chk("p_word", p_word, mon_e.pw);
        chk("wave_type", wave_type, mon_e.wv);
        chk("dds_en_on_upd", dds_en, 1);
        if (mon_e.gap != 0) chk("hold_cycles", cyc - last_upd, mon_e.gap);
      end
      last_upd = cyc;
    end else if (done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_without_upd: got done=1, expected 0 (t=%0t)", $time);
    end
  end

  task automatic go(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                    input logic [23:0] dw, input logic m, input logic [11:0] pw,
                    input logic [1:0] wv);
    @(posedge clk);
    #1;
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = m;
    p_word_in = pw; wave_type_in = wv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    bool_loop: for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_drain: got %0d pending updates, expected 0 within %0d cycles",
             name, sb_q.size(), budget);
    sb_q.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_dds_en"}, dds_en, 0);
    chk({name, "_f_word"}, f_word, 0);
    chk({name, "_p_word"}, p_word, 0);
    chk({name, "_wave"}, wave_type, 0);
    chk({name, "_upd"}, upd, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_step_cnt"}, step_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; p_word_in = '0; wave_type_in = '0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Up sweep, single shot
    push(100, 1, 0, 12'h123, 2'd1, 0);
    push(110, 2, 0, 12'h123, 2'd1, 3);
    push(120, 3, 0, 12'h123, 2'd1, 3);
    push(130, 4, 1, 12'h123, 2'd1, 3);
    go(100, 130, 10, 2, 0, 12'h123, 2'd1);
    chk("busy_in_load", busy, 1);
    drain(60, "up");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_dds_en", dds_en, 1);
    chk("hold_f_word", f_word, 130);
    chk("hold_busy", busy, 0);
    chk("hold_step_cnt", step_cnt, 4);

    // start in HOLD replays the latched descriptor, ignoring new inputs
    f_start = 999; p_word_in = 12'h777;
    push(100, 1, 0, 12'h123, 2'd1, 0);
    push(110, 2, 0, 12'h123, 2'd1, 3);
    push(120, 3, 0, 12'h123, 2'd1, 3);
    push(130, 4, 1, 12'h123, 2'd1, 3);
    pulse_start();
    drain(60, "hold_restart");
    pulse_abort();
    chk("abort_hold_dds_en", dds_en, 0);
    chk("abort_hold_f_word", f_word, 130);

    // Down sweep with overshoot clamp
    push(100, 1, 0, 12'h0a5, 2'd2, 0);
    push(90, 2, 0, 12'h0a5, 2'd2, 2);
    push(80, 3, 0, 12'h0a5, 2'd2, 2);
    push(75, 4, 1, 12'h0a5, 2'd2, 2);
    go(100, 75, 10, 1, 0, 12'h0a5, 2'd2);
    drain(60, "down");
    repeat (4) @(posedge clk);
    #1 chk("down_hold_f_word", f_word, 75);
    pulse_abort();

    // Overflow clamp, dwell 0 behaves as 1
    push(32'hFFFF_FFF0, 1, 0, 12'hfff, 2'd3, 0);
    push(32'hFFFF_FFFF, 2, 1, 12'hfff, 2'd3, 2);
    go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0, 12'hfff, 2'd3);
    drain(40, "ovf");
    repeat (3) @(posedge clk);
    #1 chk("ovf_hold_f_word", f_word, 32'hFFFF_FFFF);
    pulse_abort();

    // Continuous mode, f_start == f_stop: upd only on each LOAD
    push(50, 1, 0, 12'h050, 2'd0, 0);
    for (int i = 0; i < 3; i++) push(50, 1, 0, 12'h050, 2'd0, 5);
    go(50, 50, 5, 3, 1, 12'h050, 2'd0);
    drain(60, "cont");
    pulse_abort();
    chk("cont_abort_dds_en", dds_en, 0);
    repeat (8) @(posedge clk);

    // Abort during DWELL of 110 with simultaneous start
    push(100, 1, 0, 12'h123, 2'd1, 0);
    push(110, 2, 0, 12'h123, 2'd1, 3);
    go(100, 130, 10, 2, 0, 12'h123, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_dds_en", dds_en, 0);
    chk("abort_f_word", f_word, 110);
    chk("abort_step_cnt", step_cnt, 2);
    chk("abort_busy", busy, 0);
    chk("abort_upd", upd, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_idle_f_word", f_word, 110);
    chk("abort_idle_dds_en", dds_en, 0);
    drain(4, "abort");

    // Asynchronous reset mid-DWELL, then a clean sweep
    push(100, 1, 0, 12'h123, 2'd1, 0);
    go(100, 130, 10, 2, 0, 12'h123, 2'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain(4, "midrst");
    push(100, 1, 0, 12'h3c3, 2'd2, 0);
    push(90, 2, 0, 12'h3c3, 2'd2, 2);
    push(80, 3, 0, 12'h3c3, 2'd2, 2);
    push(75, 4, 1, 12'h3c3, 2'd2, 2);
    go(100, 75, 10, 1, 0, 12'h3c3, 2'd2);
    drain(60, "post_rst");
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
